load_store_queue: RTL
=====================

LOAD_STORE_QUEUE -- requirements
Module: load_store_queue

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 3, log2 of entry count (DEPTH = 2**DEPTH_LOG).
REQ-002 SHALL have parameter ID_WIDTH, default 4, ROB tag width.
REQ-003 SHALL have parameter XLEN, default 32, data/address width.
REQ-004 SHALL have ports:
- clk  in  1  clock. One clock.
- rst_in  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global enable. Low freezes all state.
- flush  in  1  mispredict squash.
- full  out  1  no free entry.
- issue_en  in  1  allocate entry.
- issue_op  in  3  0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
- issue_imm  in  XLEN  address offset.
- issue_tag  in  ID_WIDTH  ROB tag.
- rdy1, rdy2  in  1 each  operand valid (base, store data).
- v1, v2  in  XLEN each  operand values.
- q1, q2  in  ID_WIDTH each  producer tags.
- cdb_en  in  1  result broadcast valid.
- cdb_tag  in  ID_WIDTH  broadcast tag.
- cdb_val  in  XLEN  broadcast value.
- commit_en  in  1  ROB commits a store.
- commit_tag  in  ID_WIDTH  committed store tag.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  XLEN  address.
- mem_wdata  out  XLEN  store data.
- mem_size  out  2  0 byte, 1 half, 2 word.
- mem_done  in  1  request complete.
- mem_rdata  in  XLEN  raw load data, LSB-aligned.
- out_en  out  1  load result valid.
- out_tag  out  ID_WIDTH  load ROB tag.
- out_val  out  XLEN  extended load result.

Function
REQ-005 SHALL be a circular queue of DEPTH entries with head, tail (DEPTH_LOG bits, wrapping) and count (DEPTH_LOG+1 bits).
REQ-006 SHALL drive full = (count == DEPTH) combinationally; issue_en while full SHALL be ignored.
REQ-007 SHALL, on issue_en and not full, write the entry at tail and advance tail.
REQ-008 SHALL, when a CDB broadcast matches an incoming issue operand tag in the same cycle, store that operand as ready with cdb_val.
REQ-009 SHALL, every cycle cdb_en is high, capture cdb_val into every valid entry waiting on cdb_tag.
REQ-010 SHALL mark the entry with matching tag committed when commit_en is high; a commit to an entry being issued in the same cycle SHALL NOT occur.
REQ-011 SHALL execute strictly in order from head only.
REQ-012 SHALL use a two-state FSM:
- IDLE -> WAIT when head is valid, base ready, and either a load, or a store that is committed with data ready. mem_req rises one cycle after the decision.
- WAIT -> IDLE on mem_done. Head retires the same cycle.
REQ-013 SHALL hold mem_req, mem_we, mem_addr, mem_wdata and mem_size stable throughout WAIT.
REQ-014 SHALL compute mem_addr = base + imm modulo 2**XLEN.
REQ-015 SHALL, on a load completion, pulse out_en for exactly one cycle, in the cycle after mem_done, with out_tag and out_val.
REQ-016 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results from mem_rdata[7:0]/[15:0].
REQ-017 SHALL keep count unchanged when allocation and retirement coincide.
REQ-018 SHALL, on flush, invalidate all uncommitted entries, set tail = head + committed_count, and set count = committed_count; committed stores survive.
REQ-019 SHALL, on flush during a load in WAIT, remain in WAIT until mem_done, then discard the result (no out_en).
REQ-020 SHALL ignore issue_en and commit_en in a flush cycle.
REQ-021 SHALL ignore flush while rdy_in is low.

Reset
REQ-022 SHALL, on rst_in high at a clock edge, clear head, tail, count, all valid and committed bits, and FSM state (IDLE), regardless of rdy_in.
REQ-023 SHALL drive mem_req = 0, out_en = 0 and full = 0 from the cycle after reset; reset mid-WAIT SHALL abandon the request.

Verification
REQ-024 Load: issue LB tag 3, v1 = 0x100 ready, imm = 4; mem_rdata = 0x80 -> mem_addr 0x104, mem_size 0, out_val 0xFFFFFF80 with out_tag 3.
REQ-025 Store hold: issue SW tag 5, all ready, no commit for 10 cycles -> mem_req stays 0; after commit_tag 5 -> mem_we 1, then retired.
REQ-026 Fill: 8 issues with no mem_done -> full = 1; 9th issue ignored; one retire with simultaneous issue -> count stays 8.
REQ-027 CDB wakeup: LW waiting on q1 = 7; cdb_tag 7 with value 0x200 -> request to 0x200+imm the cycle after the decision.
REQ-028 Flush: committed SW followed by 3 loads; flush -> count 1, store still completes, no out_en for squashed loads.
REQ-029 Wrap: 20 back-to-back LBU ops -> head and tail wrap correctly; results in issue order, zero-extended.

Source files
------------

// File: rtl/load_store_queue.sv
`default_nettype none
// ============================================================================
// load_store_queue : in-order load/store queue with CDB wakeup, store commit,
//                    flush recovery and a single outstanding memory request
// Revision 1.0
// ============================================================================
module load_store_queue #(
  parameter int DEPTH_LOG = 3,
  parameter int ID_WIDTH  = 4,
  parameter int XLEN      = 32
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  output logic                full,
  input  logic                issue_en,
  input  logic [2:0]          issue_op,
  input  logic [XLEN-1:0]     issue_imm,
  input  logic [ID_WIDTH-1:0] issue_tag,
  input  logic                rdy1,
  input  logic                rdy2,
  input  logic [XLEN-1:0]     v1,
  input  logic [XLEN-1:0]     v2,
  input  logic [ID_WIDTH-1:0] q1,
  input  logic [ID_WIDTH-1:0] q2,
  input  logic                cdb_en,
  input  logic [ID_WIDTH-1:0] cdb_tag,
  input  logic [XLEN-1:0]     cdb_val,
  input  logic                commit_en,
  input  logic [ID_WIDTH-1:0] commit_tag,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [1:0]          mem_size,
  input  logic                mem_done,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                out_en,
  output logic [ID_WIDTH-1:0] out_tag,
  output logic [XLEN-1:0]     out_val
);

  localparam int                 DEPTH    = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG:0] CNT_ONE  = (DEPTH_LOG+1)'(1);
  localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [0:0]         ST_IDLE  = 1'b0;
  localparam logic [0:0]         ST_WAIT  = 1'b1;

  logic [DEPTH_LOG-1:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d, ccnt;
  logic [DEPTH-1:0]     valid_q, cmt_q, rdy1_q, rdy2_q;
  logic [2:0]           op_q   [DEPTH];
  logic [XLEN-1:0]      imm_q  [DEPTH];
  logic [XLEN-1:0]      v1_q   [DEPTH];
  logic [XLEN-1:0]      v2_q   [DEPTH];
  logic [ID_WIDTH-1:0]  tag_q  [DEPTH];
  logic [ID_WIDTH-1:0]  q1_q   [DEPTH];
  logic [ID_WIDTH-1:0]  q2_q   [DEPTH];

  logic [0:0]          state_q;
  logic                squash_q;
  logic                mem_req_q, mem_we_q;
  logic [XLEN-1:0]     mem_addr_q, mem_wdata_q;
  logic [1:0]          mem_size_q;
  logic [2:0]          mem_op_q;
  logic [ID_WIDTH-1:0] mem_tag_q;
  logic                out_en_q;
  logic [ID_WIDTH-1:0] out_tag_q;
  logic [XLEN-1:0]     out_val_q;

  logic            w_flush, w_alloc, w_commit, w_fire, w_retire, w_load_done, w_hstore;
  logic [2:0]      w_hop;
  logic [1:0]      w_size;
  logic [XLEN-1:0] w_ext;

  assign full        = (count_q == CNT_FULL);
  assign w_flush     = rdy_in && flush;
  assign w_alloc     = rdy_in && issue_en && !full && !flush;
  assign w_commit    = rdy_in && commit_en && !flush;
  assign w_hop       = op_q[head_q];
  assign w_hstore    = (w_hop >= 3'd5);
  assign w_fire      = rdy_in && (state_q == ST_IDLE) && !flush && valid_q[head_q] &&
                       rdy1_q[head_q] && (!w_hstore || (cmt_q[head_q] && rdy2_q[head_q]));
  // A squashed in-flight load already left the queue at flush time, so its completion retires nothing.
  assign w_retire    = rdy_in && (state_q == ST_WAIT) && mem_done && !squash_q;
  assign w_load_done = w_retire && !mem_we_q && !flush;

  always_comb begin
    case (w_hop)
      3'd0, 3'd3, 3'd5: w_size = 2'd0;
      3'd1, 3'd4, 3'd6: w_size = 2'd1;
      default:          w_size = 2'd2;
    endcase
  end

  always_comb begin
    case (mem_op_q)
      3'd0:    w_ext = {{(XLEN-8){mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    w_ext = {{(XLEN-16){mem_rdata[15]}}, mem_rdata[15:0]};
      3'd3:    w_ext = {{(XLEN-8){1'b0}}, mem_rdata[7:0]};
      3'd4:    w_ext = {{(XLEN-16){1'b0}}, mem_rdata[15:0]};
      default: w_ext = mem_rdata;
    endcase
  end

  // Committed stores are always the oldest entries, so they sit contiguously from head.
  always_comb begin
    ccnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && cmt_q[i] && !(w_retire && head_q == DEPTH_LOG'(i))) begin
        ccnt = ccnt + CNT_ONE;
      end
    end
    head_d = w_retire ? head_q + PTR_ONE : head_q;
    if (w_flush) begin
      tail_d  = head_d + ccnt[DEPTH_LOG-1:0];
      count_d = ccnt;
    end else begin
      tail_d  = w_alloc ? tail_q + PTR_ONE : tail_q;
      count_d = count_q;
      if (w_alloc && !w_retire) begin
        count_d = count_q + CNT_ONE;
      end else if (!w_alloc && w_retire) begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      valid_q     <= '0;
      cmt_q       <= '0;
      state_q     <= ST_IDLE;
      squash_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      mem_op_q    <= '0;
      mem_tag_q   <= '0;
      out_en_q    <= 1'b0;
      out_tag_q   <= '0;
      out_val_q   <= '0;
    end else begin
      out_en_q <= w_load_done;
      if (w_load_done) begin
        out_tag_q <= mem_tag_q;
        out_val_q <= w_ext;
      end
      if (rdy_in) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        for (int i = 0; i < DEPTH; i++) begin
          if (w_retire && head_q == DEPTH_LOG'(i)) begin
            valid_q[i] <= 1'b0;
            cmt_q[i]   <= 1'b0;
          end else if (w_flush && !cmt_q[i]) begin
            valid_q[i] <= 1'b0;
          end else if (w_commit && valid_q[i] && tag_q[i] == commit_tag) begin
            cmt_q[i] <= 1'b1;
          end
        end
        if (w_alloc) begin
          valid_q[tail_q] <= 1'b1;
          cmt_q[tail_q]   <= 1'b0;
        end
        case (state_q)
          ST_IDLE: begin
            if (w_fire) begin
              state_q     <= ST_WAIT;
              mem_req_q   <= 1'b1;
              mem_we_q    <= w_hstore;
              mem_addr_q  <= v1_q[head_q] + imm_q[head_q];
              mem_wdata_q <= v2_q[head_q];
              mem_size_q  <= w_size;
              mem_op_q    <= w_hop;
              mem_tag_q   <= tag_q[head_q];
            end
          end
          ST_WAIT: begin
            if (mem_done) begin
              state_q   <= ST_IDLE;
              mem_req_q <= 1'b0;
              squash_q  <= 1'b0;
            end else if (flush && !mem_we_q) begin
              squash_q <= 1'b1;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy_in) begin
      if (cdb_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && !rdy1_q[i] && q1_q[i] == cdb_tag) begin
            rdy1_q[i] <= 1'b1;
            v1_q[i]   <= cdb_val;
          end
          if (valid_q[i] && !rdy2_q[i] && q2_q[i] == cdb_tag) begin
            rdy2_q[i] <= 1'b1;
            v2_q[i]   <= cdb_val;
          end
        end
      end
      if (w_alloc) begin
        op_q[tail_q]   <= issue_op;
        imm_q[tail_q]  <= issue_imm;
        tag_q[tail_q]  <= issue_tag;
        q1_q[tail_q]   <= q1;
        q2_q[tail_q]   <= q2;
        rdy1_q[tail_q] <= rdy1 || (cdb_en && q1 == cdb_tag);
        rdy2_q[tail_q] <= rdy2 || (cdb_en && q2 == cdb_tag);
        v1_q[tail_q]   <= rdy1 ? v1 : cdb_val;
        v2_q[tail_q]   <= rdy2 ? v2 : cdb_val;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign out_en    = out_en_q;
  assign out_tag   = out_tag_q;
  assign out_val   = out_val_q;

endmodule
`default_nettype wire
